// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ALU issue stage: operand forwarding, RAW stall, valid/ready issue.
// Optional feature macro: ALU_OPSTAGE_SKID_EN adds a second (skid) entry so dec_ready is decoupled from alu_ready.
module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int OPW  = 4,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [RAW-1:0]  dec_rs1,
  input  logic [RAW-1:0]  dec_rs2,
  input  logic [XLEN-1:0] dec_r1,
  input  logic [XLEN-1:0] dec_r2,
  input  logic [XLEN-1:0] dec_imm,
  input  logic            dec_use_imm,
  input  logic [OPW-1:0]  dec_op,
  input  logic [RAW-1:0]  dec_rd,
  input  logic            ex_fwd_valid,
  input  logic [RAW-1:0]  ex_fwd_rd,
  input  logic [XLEN-1:0] ex_fwd_data,
  input  logic            wb_we,
  input  logic [RAW-1:0]  wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            alu_valid,
  input  logic            alu_ready,
  output logic [XLEN-1:0] alu_d1,
  output logic [XLEN-1:0] alu_d2,
  output logic [OPW-1:0]  alu_op,
  output logic [RAW-1:0]  alu_rd
);

  logic [XLEN-1:0] in_d1, in_d2;
  logic            m_free, fire, hazard;

  // EX is younger than WB, so it takes priority; x0 always reads zero.
  always_comb begin
    in_d1 = dec_r1;
    if (dec_rs1 == '0)                               in_d1 = '0;
    else if (ex_fwd_valid && (ex_fwd_rd == dec_rs1)) in_d1 = ex_fwd_data;
    else if (wb_we && (wb_rd == dec_rs1))            in_d1 = wb_data;

    in_d2 = dec_r2;
    if (dec_use_imm)                                 in_d2 = dec_imm;
    else if (dec_rs2 == '0)                          in_d2 = '0;
    else if (ex_fwd_valid && (ex_fwd_rd == dec_rs2)) in_d2 = ex_fwd_data;
    else if (wb_we && (wb_rd == dec_rs2))            in_d2 = wb_data;
  end

  function automatic logic depends(input logic v, input logic [RAW-1:0] rd,
                                   input logic [RAW-1:0] rs1, input logic [RAW-1:0] rs2,
                                   input logic use_imm);
    return v && (rd != '0) &&
           (((rs1 != '0) && (rs1 == rd)) || (!use_imm && (rs2 != '0) && (rs2 == rd)));
  endfunction

  assign m_free = !alu_valid || alu_ready;
  assign fire   = dec_valid && dec_ready;

`ifdef ALU_OPSTAGE_SKID_EN
  logic            s_valid;
  logic [XLEN-1:0] s_d1, s_d2;
  logic [OPW-1:0]  s_op;
  logic [RAW-1:0]  s_rd;

  assign hazard = depends(alu_valid, alu_rd, dec_rs1, dec_rs2, dec_use_imm) ||
                  depends(s_valid, s_rd, dec_rs1, dec_rs2, dec_use_imm);
  assign dec_ready = !rst && !s_valid && !hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_valid <= 1'b0;
      alu_d1    <= '0;
      alu_d2    <= '0;
      alu_op    <= '0;
      alu_rd    <= '0;
      s_valid   <= 1'b0;
      s_d1      <= '0;
      s_d2      <= '0;
      s_op      <= '0;
      s_rd      <= '0;
    end else if (m_free) begin
      // While S is valid dec_ready is low, so no incoming transfer competes with S.
      if (s_valid) begin
        alu_valid <= 1'b1;
        alu_d1    <= s_d1;
        alu_d2    <= s_d2;
        alu_op    <= s_op;
        alu_rd    <= s_rd;
        s_valid   <= 1'b0;
      end else if (fire) begin
        alu_valid <= 1'b1;
        alu_d1    <= in_d1;
        alu_d2    <= in_d2;
        alu_op    <= dec_op;
        alu_rd    <= dec_rd;
      end else begin
        alu_valid <= 1'b0;
      end
    end else if (fire) begin
      s_valid <= 1'b1;
      s_d1    <= in_d1;
      s_d2    <= in_d2;
      s_op    <= dec_op;
      s_rd    <= dec_rd;
    end
  end
`else
  assign hazard    = depends(alu_valid, alu_rd, dec_rs1, dec_rs2, dec_use_imm);
  assign dec_ready = !rst && m_free && !hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_valid <= 1'b0;
      alu_d1    <= '0;
      alu_d2    <= '0;
      alu_op    <= '0;
      alu_rd    <= '0;
    end else if (m_free) begin
      alu_valid <= fire;
      if (fire) begin
        alu_d1 <= in_d1;
        alu_d2 <= in_d2;
        alu_op <= dec_op;
        alu_rd <= dec_rd;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - randomized + directed bench for alu_operand_stage against a queue model.
module tb_alu_operand_stage;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [3:0]  op;
    logic [4:0]  rd;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_ready, dec_use_imm;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [31:0] dec_r1, dec_r2, dec_imm;
  logic [3:0]  dec_op;
  logic        ex_fwd_valid, wb_we;
  logic [4:0]  ex_fwd_rd, wb_rd;
  logic [31:0] ex_fwd_data, wb_data;
  logic        alu_valid, alu_ready;
  logic [31:0] alu_d1, alu_d2;
  logic [3:0]  alu_op;
  logic [4:0]  alu_rd;

  int n_tests = 0;
  int n_fail  = 0;
  entry_t q[$];

`ifdef ALU_OPSTAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  alu_operand_stage dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_r1(dec_r1), .dec_r2(dec_r2),
    .dec_imm(dec_imm), .dec_use_imm(dec_use_imm), .dec_op(dec_op), .dec_rd(dec_rd),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_d1(alu_d1), .alu_d2(alu_d2), .alu_op(alu_op), .alu_rd(alu_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Value a source should read: zero register, youngest forward, then regfile.
  function automatic logic [31:0] src_value(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0) return 32'h0;
    if (ex_fwd_valid && ex_fwd_rd == rs) return ex_fwd_data;
    if (wb_we && wb_rd == rs) return wb_data;
    return rf;
  endfunction

  task automatic set_dec(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                         input logic ui, input logic [3:0] op, input logic [4:0] rd);
    dec_valid = v; dec_rs1 = rs1; dec_rs2 = rs2; dec_r1 = r1; dec_r2 = r2;
    dec_imm = imm; dec_use_imm = ui; dec_op = op; dec_rd = rd;
  endtask

  task automatic set_fwd(input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                         input logic wv, input logic [4:0] wrd, input logic [31:0] wd);
    ex_fwd_valid = ev; ex_fwd_rd = erd; ex_fwd_data = ed;
    wb_we = wv; wb_rd = wrd; wb_data = wd;
  endtask

  // Called just after a falling edge with inputs set; returns at the next falling edge.
  task automatic step();
    logic   haz, exp_rdy, fire, cons;
    entry_t e;
    haz = 1'b0;
    foreach (q[i])
      if (q[i].rd != 0 && ((dec_rs1 != 0 && dec_rs1 == q[i].rd) ||
                           (!dec_use_imm && dec_rs2 != 0 && dec_rs2 == q[i].rd)))
        haz = 1'b1;
`ifdef ALU_OPSTAGE_SKID_EN
    exp_rdy = (q.size() < CAP) && !haz;
`else
    exp_rdy = (q.size() == 0 || alu_ready) && !haz;
`endif
    #1;
    check("dec_ready", dec_ready, exp_rdy);
    check("alu_valid", alu_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("alu_d1", alu_d1, q[0].d1);
      check("alu_d2", alu_d2, q[0].d2);
      check("alu_op", alu_op, q[0].op);
      check("alu_rd", alu_rd, q[0].rd);
    end
    fire = dec_valid && exp_rdy;
    cons = (q.size() != 0) && alu_ready;
    e.d1 = src_value(dec_rs1, dec_r1);
    e.d2 = dec_use_imm ? dec_imm : src_value(dec_rs2, dec_r2);
    e.op = dec_op;
    e.rd = dec_rd;
    @(posedge clk);
    if (cons) void'(q.pop_front());
    if (fire) q.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    alu_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
  endtask

  initial begin
    rst = 1'b1;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    alu_ready = 1'b0;
    #2;
    check("rst_alu_valid", alu_valid, 0);
    check("rst_alu_d1", alu_d1, 0);
    check("rst_dec_ready", dec_ready, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    step();

    // Regfile path
    set_dec(1, 3, 4, 32'h11, 32'h22, 0, 0, 2, 9);
    alu_ready = 1'b1;
    step();
    check("rf_d1", alu_d1, 32'h11);
    check("rf_d2", alu_d2, 32'h22);
    check("rf_op", alu_op, 2);

    // Forward priority: EX over WB over regfile
    set_dec(1, 5, 0, 32'hCCCC, 0, 0, 0, 1, 1);
    set_fwd(1, 5, 32'hAAAA, 1, 5, 32'hBBBB);
    step();
    check("fwd_ex", alu_d1, 32'hAAAA);
    ex_fwd_valid = 1'b0;
    step();
    check("fwd_wb", alu_d1, 32'hBBBB);

    // x0 reads zero; rd=0 never stalls
    set_dec(1, 0, 0, 32'hDEAD, 0, 0, 0, 3, 0);
    set_fwd(1, 0, 32'hBEEF, 1, 0, 32'h1234);
    step();
    check("x0_d1", alu_d1, 0);
    set_dec(1, 0, 0, 32'h5, 32'h6, 0, 0, 4, 2);
    #1;
    check("x0_no_stall", dec_ready, 1);
    step();

    // RAW hazard on a queued producer, resolved through EX forward
    drain();
    set_dec(1, 1, 2, 32'h1, 32'h2, 0, 0, 5, 7);
    alu_ready = 1'b0;
    step();
    set_dec(1, 0, 7, 0, 32'h9999, 0, 0, 6, 8);
    #1;
    check("haz_stall", dec_ready, 0);
    step();
    alu_ready = 1'b1;
    step();
    set_fwd(1, 7, 32'h7777, 0, 0, 0);
    step();
    check("haz_fwd_d2", alu_d2, 32'h7777);
    check("haz_rd", alu_rd, 8);

`ifdef ALU_OPSTAGE_SKID_EN
    // Backpressure fills M and S, then drains in order
    drain();
    alu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_dec(1, 5'(20 + i), 0, 32'(i), 0, 0, 0, 4'(i), 5'(10 + i));
      step();
    end
    check("bp_full", dec_ready, 0);
    alu_ready = 1'b1;
    step();
    check("bp_order", alu_rd, 11);
    step();
    step();
    check("bp_last", alu_rd, 12);
`endif

    // Randomized traffic against the queue model
    drain();
    for (int i = 0; i < 600; i++) begin
      set_dec($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              $urandom, $urandom, $urandom, $urandom_range(0, 3) == 0,
              4'($urandom), 5'($urandom_range(0, 7)));
      set_fwd($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      alu_ready = $urandom_range(0, 4) < 3;
      step();
    end

    // Reset mid-stream with the stage full
    drain();
    set_fwd(0, 0, 0, 0, 0, 0);
    alu_ready = 1'b0;
    set_dec(1, 0, 0, 32'h55, 0, 0, 0, 1, 20);
    step();
    set_dec(1, 0, 0, 32'h66, 0, 0, 0, 1, 21);
    step();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_alu_valid", alu_valid, 0);
    check("midrst_alu_d1", alu_d1, 0);
    check("midrst_dec_ready", dec_ready, 0);
    q.delete();
    dec_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    check("postrst_alu_valid", alu_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
